// File: rtl/wb_pkg.sv
// Shared types for the writeback merge stage: register index, data word and queued entry.
package wb_pkg;

    localparam int WB_REGF_W = 5;
    localparam int WB_DATA_W = 32;

    typedef logic [WB_REGF_W-1:0] regf_t;
    typedef logic [WB_DATA_W-1:0] data_t;

    typedef struct packed {
        regf_t regf;
        data_t data;
    } wb_entry_t;

    localparam regf_t REG_ZERO = '0;

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO; exposes every slot in age order (oldest first) for hazard queries.
module wb_chan_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output wb_entry_t [DEPTH-1:0]       ord_entry,
    output logic      [DEPTH-1:0]       ord_valid
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    wb_entry_t        mem [DEPTH];

    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_entry;
    end

    // Slot j is the j-th oldest entry; the low pointer bits wrap naturally for power-of-2 DEPTH.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ord_entry[j] = mem[rd_ptr[IDX_W-1:0] + IDX_W'(j)];
            ord_valid[j] = (PTR_W'(j) < count);
        end
    end

endmodule

// File: rtl/wb_multi.sv
// Writeback merge: NUM_CH queued result channels, round-robin onto one registered regfile port.
// Define WB_FWD_EN to forward pending data on qry_data; otherwise qry_data is tied to 0.
module wb_multi
    import wb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int REGF_W = WB_REGF_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH*REGF_W-1:0]   ch_regf,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       rd_we,
    output logic [REGF_W-1:0]          rd_regf,
    output logic [DATA_W-1:0]          rd_data,
    input  logic [REGF_W-1:0]          qry_regf,
    output logic                       qry_hit,
    output logic [DATA_W-1:0]          qry_data,
    output logic                       busy
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    push;
    logic [NUM_CH-1:0]    pop;
    wb_entry_t [DEPTH-1:0] ord_entry [NUM_CH];
    logic      [DEPTH-1:0] ord_valid [NUM_CH];

    logic [RR_W-1:0]      rr;
    logic [RR_W-1:0]      grant_idx;
    logic                 grant_vld;
    wb_entry_t            head;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        wb_entry_t in_entry;

        assign in_entry.regf = ch_regf[g*REGF_W +: REGF_W];
        assign in_entry.data = ch_data[g*DATA_W +: DATA_W];
        assign ch_ready[g]   = rst_n && !full[g];
        assign push[g]       = ch_valid[g] && ch_ready[g];
        assign pop[g]        = grant_vld && (int'(grant_idx) == g);

        wb_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .push       (push[g]),
            .push_entry (in_entry),
            .pop        (pop[g]),
            .full       (full[g]),
            .empty      (empty[g]),
            .ord_entry  (ord_entry[g]),
            .ord_valid  (ord_valid[g])
        );
    end

    // First non-empty channel at or after rr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = int'(rr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!grant_vld && !empty[c]) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(c);
            end
        end
    end

    assign head = ord_entry[grant_idx][0];

    // Zero-register entries still consume their slot but never raise rd_we or disturb rd_regf/rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr      <= '0;
            rd_we   <= 1'b0;
            rd_regf <= '0;
            rd_data <= '0;
        end else if (flush) begin
            rr    <= '0;
            rd_we <= 1'b0;
        end else begin
            rd_we <= 1'b0;
            if (grant_vld) begin
                if (int'(grant_idx) == NUM_CH - 1) rr <= '0;
                else                               rr <= grant_idx + 1'b1;
                if (head.regf != REG_ZERO) begin
                    rd_we   <= 1'b1;
                    rd_regf <= head.regf;
                    rd_data <= head.data;
                end
            end
        end
    end

    assign busy = (~&empty) || rd_we;

    always_comb begin
        qry_hit = rd_we && (rd_regf == qry_regf);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ord_valid[c][j] && (ord_entry[c][j].regf == qry_regf)) qry_hit = 1'b1;
            end
        end
        if (qry_regf == REG_ZERO) qry_hit = 1'b0;
    end

`ifdef WB_FWD_EN
    // Later assignments win: output register first, then channels high to low, oldest to youngest.
    always_comb begin
        qry_data = '0;
        if (rd_we && (rd_regf == qry_regf)) qry_data = rd_data;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ord_valid[c][j] && (ord_entry[c][j].regf == qry_regf))
                    qry_data = ord_entry[c][j].data;
            end
        end
        if (qry_regf == REG_ZERO) qry_data = '0;
    end
`else
    logic unused_ord_data;

    assign qry_data = '0;

    always_comb begin
        unused_ord_data = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < DEPTH; j++) unused_ord_data = unused_ord_data ^ (^ord_entry[c][j].data);
        end
    end
`endif

endmodule

// File: tb/tb_wb_multi.sv
// Directed self-checking bench for wb_multi (NUM_CH=3, DEPTH=4, DATA_W=32, REGF_W=5).
module tb_wb_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  ch_valid;
    logic [2:0]  ch_ready;
    logic [14:0] ch_regf;
    logic [95:0] ch_data;
    logic        rd_we;
    logic [4:0]  rd_regf;
    logic [31:0] rd_data;
    logic [4:0]  qry_regf;
    logic        qry_hit;
    logic [31:0] qry_data;
    logic        busy;

    int passed = 0;
    int total  = 0;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_multi dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_regf  (ch_regf),
        .ch_data  (ch_data),
        .rd_we    (rd_we),
        .rd_regf  (rd_regf),
        .rd_data  (rd_data),
        .qry_regf (qry_regf),
        .qry_hit  (qry_hit),
        .qry_data (qry_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ch_valid = '0;
        ch_regf  = '0;
        ch_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [4:0] r, input logic [31:0] d);
        ch_valid[i]        = 1'b1;
        ch_regf[i*5 +: 5]  = r;
        ch_data[i*32 +: 32] = d;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        qry_regf = 5'd3;
        idle_inputs();
        #2;
        total++; if (ch_ready !== 3'b000) $display("FAIL reset_ch_ready: got %b want 000", ch_ready); else passed++;
        total++; if (rd_we !== 1'b0) $display("FAIL reset_rd_we: got %b want 0", rd_we); else passed++;
        total++; if (rd_regf !== 5'd0) $display("FAIL reset_rd_regf: got %0d want 0", rd_regf); else passed++;
        total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (qry_hit !== 1'b0) $display("FAIL reset_qry_hit: got %b want 0", qry_hit); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (ch_ready !== 3'b111) $display("FAIL reset_release_ready: got %b want 111", ch_ready); else passed++;
    endtask

    task automatic test_single;
        qry_regf = 5'd3;
        set_ch(0, 5'd3, 32'h1234);
        tick();
        idle_inputs();
        total++; if (rd_we !== 1'b0) $display("FAIL single_early_we: got %b want 0", rd_we); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_queued: got %b want 1", busy); else passed++;
        total++; if (qry_hit !== 1'b1) $display("FAIL single_qry_fifo: got %b want 1", qry_hit); else passed++;
        tick();
        total++; if (rd_we !== 1'b1) $display("FAIL single_we: got %b want 1", rd_we); else passed++;
        total++; if (rd_regf !== 5'd3) $display("FAIL single_regf: got %0d want 3", rd_regf); else passed++;
        total++; if (rd_data !== 32'h1234) $display("FAIL single_data: got %h want 1234", rd_data); else passed++;
        total++; if (qry_hit !== 1'b1) $display("FAIL single_qry_out: got %b want 1", qry_hit); else passed++;
        tick();
        total++; if (rd_we !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", rd_we); else passed++;
        total++; if (rd_regf !== 5'd3) $display("FAIL single_regf_hold: got %0d want 3", rd_regf); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_d [2:5];
        logic [4:0]  exp_r;
        int          n;
        exp_d[2] = {16'd1, 16'd0};
        exp_d[3] = {16'd1, 16'd1};
        exp_d[4] = {16'd1, 16'd2};
        exp_d[5] = {16'd2, 16'd0};
        do_flush();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            for (int i = 0; i < 3; i++) set_ch(i, 5'(i + 1), {16'(cyc), 16'(i)});
            tick();
            if (cyc >= 2) begin
                exp_r = 5'((cyc - 2) % 3 + 1);
                total++; if (rd_we !== 1'b1) $display("FAIL rr_we_c%0d: got %b want 1", cyc, rd_we); else passed++;
                total++; if (rd_regf !== exp_r) $display("FAIL rr_grant_c%0d: got %0d want %0d", cyc, rd_regf, exp_r); else passed++;
            end
            if (cyc >= 2 && cyc <= 5) begin
                total++; if (rd_data !== exp_d[cyc]) $display("FAIL rr_data_c%0d: got %h want %h", cyc, rd_data, exp_d[cyc]); else passed++;
            end
            if (cyc == 5) begin
                total++; if (ch_ready !== 3'b001) $display("FAIL rr_ready_full: got %b want 001", ch_ready); else passed++;
            end
        end
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++; if (busy !== 1'b0) $display("FAIL rr_drain: busy still %b after %0d cycles", busy, n); else passed++;
    endtask

    task automatic test_zero_reg;
        set_ch(0, 5'd0, 32'hFFFF);
        tick();
        idle_inputs();
        qry_regf = 5'd0;
        #1;
        total++; if (busy !== 1'b1) $display("FAIL zero_busy_queued: got %b want 1", busy); else passed++;
        total++; if (qry_hit !== 1'b0) $display("FAIL zero_qry_r0: got %b want 0", qry_hit); else passed++;
        tick();
        total++; if (rd_we !== 1'b0) $display("FAIL zero_no_write: got %b want 0", rd_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL zero_busy_clear: got %b want 0", busy); else passed++;
    endtask

    task automatic test_flush;
        set_ch(1, 5'd5, 32'h55);
        set_ch(2, 5'd6, 32'h66);
        tick();
        idle_inputs();
        qry_regf = 5'd6;
        #1;
        total++; if (qry_hit !== 1'b1) $display("FAIL flush_pre_hit: got %b want 1", qry_hit); else passed++;
        flush = 1'b1;
        set_ch(0, 5'd9, 32'h99);
        tick();
        idle_inputs();
        qry_regf = 5'd9;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else passed++;
        total++; if (rd_we !== 1'b0) $display("FAIL flush_rd_we: got %b want 0", rd_we); else passed++;
        total++; if (ch_ready !== 3'b111) $display("FAIL flush_ready: got %b want 111", ch_ready); else passed++;
        total++; if (qry_hit !== 1'b0) $display("FAIL flush_push_dropped: got %b want 0", qry_hit); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (rd_we !== 1'b0) $display("FAIL flush_late_write_%0d: got %b want 0", k, rd_we); else passed++;
        end
    endtask

    task automatic test_forward;
        do_flush();
        set_ch(1, 5'd7, 32'hA);
        set_ch(2, 5'd7, 32'hC);
        tick();
        idle_inputs();
        qry_regf = 5'd7;
        #1;
        total++; if (qry_hit !== 1'b1) $display("FAIL fwd_hit_1: got %b want 1", qry_hit); else passed++;
        total++; if (qry_data !== (FWD ? 32'hA : 32'h0)) $display("FAIL fwd_data_1: got %h want %h", qry_data, FWD ? 32'hA : 32'h0); else passed++;
        set_ch(1, 5'd7, 32'hB);
        tick();
        idle_inputs();
        total++; if (rd_we !== 1'b1) $display("FAIL fwd_rd_we: got %b want 1", rd_we); else passed++;
        total++; if (rd_data !== 32'hA) $display("FAIL fwd_rd_data: got %h want a", rd_data); else passed++;
        total++; if (qry_hit !== 1'b1) $display("FAIL fwd_hit_2: got %b want 1", qry_hit); else passed++;
        total++; if (qry_data !== (FWD ? 32'hB : 32'h0)) $display("FAIL fwd_data_2: got %h want %h", qry_data, FWD ? 32'hB : 32'h0); else passed++;
        qry_regf = 5'd8;
        #1;
        total++; if (qry_hit !== 1'b0) $display("FAIL fwd_miss_hit: got %b want 0", qry_hit); else passed++;
        total++; if (qry_data !== 32'h0) $display("FAIL fwd_miss_data: got %h want 0", qry_data); else passed++;
        do_flush();
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) set_ch(i, 5'(10 + i), 32'(k * 16 + i));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rd_we !== 1'b0) $display("FAIL rst_mid_we: got %b want 0", rd_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
        total++; if (ch_ready !== 3'b000) $display("FAIL rst_mid_ready: got %b want 000", ch_ready); else passed++;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (ch_ready !== 3'b111) $display("FAIL rst_mid_release: got %b want 111", ch_ready); else passed++;
        tick();
        total++; if (rd_we !== 1'b0) $display("FAIL rst_mid_lost: got %b want 0", rd_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_lost_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_flush();
        test_forward();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
